// File: rtl/cruz_pkg.sv
// cruz_pkg: shared definitions for the two-approach intersection controller.
//   - cruz_state_e : controller phase encoding (codes 6/7 are illegal)
//   - default timing constants used as parameter defaults by cruzamento_ctrl
//   - RECOVER_STATE : where an illegal state code goes on the next edge
//   - cruz_lamp_t / lamp_decode : one signal head, exactly one lamp lit
package cruz_pkg;

  typedef enum logic [2:0] {
    AR_TO_A = 3'd0,
    A_GRN   = 3'd1,
    A_YEL   = 3'd2,
    AR_TO_B = 3'd3,
    B_GRN   = 3'd4,
    B_YEL   = 3'd5
  } cruz_state_e;

  localparam int T_GREEN_MIN_DEF = 8;
  localparam int T_GREEN_MAX_DEF = 20;
  localparam int T_YELLOW_DEF    = 4;
  localparam int T_ALLRED_DEF    = 2;
  localparam int CW_DEF          = 5;

  // Illegal codes fall back into the all-red clearance ahead of side A.
  localparam cruz_state_e RECOVER_STATE = AR_TO_A;

  typedef struct packed {
    logic green;
    logic yellow;
    logic red;
  } cruz_lamp_t;

  // Red whenever the side is neither green nor yellow.
  function automatic cruz_lamp_t lamp_decode(input logic grn, input logic yel);
    cruz_lamp_t l;
    l.green  = grn;
    l.yellow = yel & ~grn;
    l.red    = ~grn & ~yel;
    return l;
  endfunction

endpackage

// File: rtl/cruz_timer.sv
// cruz_timer: CW-bit saturating phase counter.
//   clk, rst_n : clock, async active-low reset (count -> 0)
//   clr        : clear to 0 on the next edge (takes priority over counting)
//   cnt        : current count; holds at all-ones instead of wrapping
module cruz_timer #(
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  output logic [CW-1:0] cnt
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (cnt_q != {CW{1'b1}})
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/cruzamento_ctrl.sv
// cruzamento_ctrl: right-of-way controller for two approaches (A, B).
// Cycles AR_TO_A -> A_GRN -> A_YEL -> AR_TO_B -> B_GRN -> B_YEL with
// min/max green timing and latched per-side demand.
//   clk, rst_n          : clock, async active-low reset
//   req_a, req_b        : level demand inputs, sampled every cycle
//   a_/b_ green/yellow/red : registered lamp outputs, one lit per side
//   pend_a, pend_b      : latched demand flags
//   phase               : current state code
// Build option: CRUZ_REST_IN_GREEN_EN keeps green past T_GREEN_MAX until
// the opposing side has demand; undefined, green always ends at T_GREEN_MAX.
module cruzamento_ctrl
  import cruz_pkg::*;
#(
  parameter int T_GREEN_MIN = T_GREEN_MIN_DEF,
  parameter int T_GREEN_MAX = T_GREEN_MAX_DEF,
  parameter int T_YELLOW    = T_YELLOW_DEF,
  parameter int T_ALLRED    = T_ALLRED_DEF,
  parameter int CW          = CW_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_a,
  input  logic       req_b,
  output logic       a_green,
  output logic       a_yellow,
  output logic       a_red,
  output logic       b_green,
  output logic       b_yellow,
  output logic       b_red,
  output logic       pend_a,
  output logic       pend_b,
  output logic [2:0] phase
);

  // Exit compares: a duration T ends on the edge where count == T-1.
  localparam logic [CW-1:0] GMIN_M1   = CW'(T_GREEN_MIN - 1);
  localparam logic [CW-1:0] GMAX_M1   = CW'(T_GREEN_MAX - 1);
  localparam logic [CW-1:0] YEL_M1    = CW'(T_YELLOW - 1);
  localparam logic [CW-1:0] ALLRED_M1 = CW'(T_ALLRED - 1);

  cruz_state_e   state_q, state_d;
  logic          pend_a_q, pend_a_d;
  logic          pend_b_q, pend_b_d;
  cruz_lamp_t    lamp_a_q, lamp_a_d;
  cruz_lamp_t    lamp_b_q, lamp_b_d;
  logic [CW-1:0] cnt;
  logic          cnt_clr;
  logic          a_exit, b_exit;

  cruz_timer #(.CW(CW)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .cnt   (cnt)
  );

  // Green exit. The max-green term is absent in rest mode, so with no
  // opposing demand the counter just saturates while green holds.
  always_comb begin
    a_exit = (cnt >= GMIN_M1) && pend_b_q;
    b_exit = (cnt >= GMIN_M1) && pend_a_q;
`ifdef CRUZ_REST_IN_GREEN_EN
`else
    if (cnt == GMAX_M1) begin
      a_exit = 1'b1;
      b_exit = 1'b1;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      AR_TO_A: if (cnt == ALLRED_M1) state_d = A_GRN;
      A_GRN:   if (a_exit)           state_d = A_YEL;
      A_YEL:   if (cnt == YEL_M1)    state_d = AR_TO_B;
      AR_TO_B: if (cnt == ALLRED_M1) state_d = B_GRN;
      B_GRN:   if (b_exit)           state_d = B_YEL;
      B_YEL:   if (cnt == YEL_M1)    state_d = AR_TO_A;
      default:                       state_d = RECOVER_STATE;
    endcase
  end

  assign cnt_clr = (state_d != state_q);

  // Demand latch: set outside own green, cleared on entry to own green.
  // Clear is applied last so it wins over a same-edge set.
  always_comb begin
    pend_a_d = pend_a_q;
    pend_b_d = pend_b_q;
    if (state_q != A_GRN && req_a) pend_a_d = 1'b1;
    if (state_q != B_GRN && req_b) pend_b_d = 1'b1;
    if (state_d == A_GRN && state_q != A_GRN) pend_a_d = 1'b0;
    if (state_d == B_GRN && state_q != B_GRN) pend_b_d = 1'b0;
  end

  // Lamps are decoded from the next state so the lamp flops line up with
  // state_q; an illegal next state decodes to red on both sides.
  always_comb begin
    lamp_a_d = lamp_decode(state_d == A_GRN, state_d == A_YEL);
    lamp_b_d = lamp_decode(state_d == B_GRN, state_d == B_YEL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= AR_TO_A;
      pend_a_q <= 1'b0;
      pend_b_q <= 1'b0;
      lamp_a_q <= '{green: 1'b0, yellow: 1'b0, red: 1'b1};
      lamp_b_q <= '{green: 1'b0, yellow: 1'b0, red: 1'b1};
    end else begin
      state_q  <= state_d;
      pend_a_q <= pend_a_d;
      pend_b_q <= pend_b_d;
      lamp_a_q <= lamp_a_d;
      lamp_b_q <= lamp_b_d;
    end
  end

  assign a_green  = lamp_a_q.green;
  assign a_yellow = lamp_a_q.yellow;
  assign a_red    = lamp_a_q.red;
  assign b_green  = lamp_b_q.green;
  assign b_yellow = lamp_b_q.yellow;
  assign b_red    = lamp_b_q.red;
  assign pend_a   = pend_a_q;
  assign pend_b   = pend_b_q;
  assign phase    = state_q;

endmodule

// File: tb/tb_cruzamento_ctrl.sv
// Directed bench for cruzamento_ctrl with default timing parameters.
module tb_cruzamento_ctrl;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       req_a = 1'b0;
  logic       req_b = 1'b0;
  logic       a_green, a_yellow, a_red, b_green, b_yellow, b_red;
  logic       pend_a, pend_b;
  logic [2:0] phase;
  logic [5:0] lamps;

  int checks   = 0;
  int failures = 0;

  assign lamps = {a_green, a_yellow, a_red, b_green, b_yellow, b_red};

  cruzamento_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_a    (req_a),
    .req_b    (req_b),
    .a_green  (a_green),
    .a_yellow (a_yellow),
    .a_red    (a_red),
    .b_green  (b_green),
    .b_yellow (b_yellow),
    .b_red    (b_red),
    .pend_a   (pend_a),
    .pend_b   (pend_b),
    .phase    (phase)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one edge, sample 1 time unit later, check lamp sanity.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rst_n) begin
      chk("one_lamp_a", 32'($countones(lamps[5:3])), 1);
      chk("one_lamp_b", 32'($countones(lamps[2:0])), 1);
      chk("no_dual_go", 32'((a_green | a_yellow) & (b_green | b_yellow)), 0);
    end
  endtask

  // Count edges until phase leaves p (bounded).
  task automatic run_len(input logic [2:0] p, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (phase == p && n < 200);
  endtask

  initial begin
    int n;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_lamps", 32'(lamps), 32'b001001);
    chk("rst_phase", 32'(phase), 0);
    chk("rst_pend_a", 32'(pend_a), 0);
    chk("rst_pend_b", 32'(pend_b), 0);
    #5 rst_n = 1'b1;
    tick();
    chk("allred_hold", 32'(phase), 0);
    tick();
    chk("first_green", 32'(phase), 1);
    chk("first_green_lamps", 32'(lamps), 32'b100001);

`ifdef CRUZ_REST_IN_GREEN_EN
    run_len(3'd1, n);
    chk("rest_green_held", 32'(n), 200);
    chk("rest_green_lamps", 32'(lamps), 32'b100001);
    req_b = 1'b1;
    tick();
    req_b = 1'b0;
    chk("rest_pend_b", 32'(pend_b), 1);
    chk("rest_still_green", 32'(phase), 1);
    tick();
    chk("rest_yellow", 32'(phase), 2);
`else
    // Free-running alternation with no demand.
    run_len(3'd1, n); chk("a_grn_max", 32'(n), 20);
    chk("a_yel_lamps", 32'(lamps), 32'b010001);
    run_len(3'd2, n); chk("a_yel_len", 32'(n), 4);
    chk("ar_b_lamps", 32'(lamps), 32'b001001);
    run_len(3'd3, n); chk("ar_b_len", 32'(n), 2);
    chk("b_grn_lamps", 32'(lamps), 32'b001100);
    run_len(3'd4, n); chk("b_grn_max", 32'(n), 20);
    chk("b_yel_lamps", 32'(lamps), 32'b001010);
    run_len(3'd5, n); chk("b_yel_len", 32'(n), 4);
    run_len(3'd0, n); chk("ar_a_len", 32'(n), 2);
    chk("a_grn_again", 32'(phase), 1);

    // req_b pulse at count 3: green lasts 8 cycles in total.
    repeat (3) tick();
    req_b = 1'b1;
    tick();
    req_b = 1'b0;
    chk("pend_b_set", 32'(pend_b), 1);
    run_len(3'd1, n); chk("a_grn_min", 32'(n + 4), 8);
    chk("pend_b_in_yel", 32'(pend_b), 1);
    run_len(3'd2, n); chk("a_yel_len2", 32'(n), 4);
    run_len(3'd3, n); chk("ar_b_len2", 32'(n), 2);
    chk("b_grn_entry", 32'(phase), 4);
    chk("pend_b_cleared", 32'(pend_b), 0);
    run_len(3'd4, n); chk("b_grn_max2", 32'(n), 20);
    run_len(3'd5, n); chk("b_yel_len2", 32'(n), 4);
    run_len(3'd0, n); chk("ar_a_len2", 32'(n), 2);

    // req_a held through A green is ignored; req_b at count 12 ends green next edge.
    req_a = 1'b1;
    repeat (12) tick();
    chk("pend_a_ignored", 32'(pend_a), 0);
    req_b = 1'b1;
    tick();
    req_b = 1'b0;
    chk("late_req_green", 32'(phase), 1);
    chk("late_pend_b", 32'(pend_b), 1);
    tick();
    chk("late_req_yel", 32'(phase), 2);
    chk("pend_a_still_0", 32'(pend_a), 0);
    tick();
    chk("pend_a_in_yel", 32'(pend_a), 1);
    req_a = 1'b0;
    run_len(3'd2, n); chk("a_yel_rest", 32'(n), 3);
    run_len(3'd3, n); chk("ar_b_len3", 32'(n), 2);
    chk("pend_a_held", 32'(pend_a), 1);
    run_len(3'd4, n); chk("b_grn_min", 32'(n), 8);

    // Async reset in the middle of B yellow.
    chk("b_yel_lamps2", 32'(lamps), 32'b001010);
    req_b = 1'b1;
    tick();
    req_b = 1'b0;
    chk("mid_b_yel", 32'(phase), 5);
    chk("pend_b_pre_rst", 32'(pend_b), 1);
    chk("pend_a_pre_rst", 32'(pend_a), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_lamps", 32'(lamps), 32'b001001);
    chk("arst_phase", 32'(phase), 0);
    chk("arst_pend_a", 32'(pend_a), 0);
    chk("arst_pend_b", 32'(pend_b), 0);
    #4 rst_n = 1'b1;
    tick();
    chk("rel_allred", 32'(phase), 0);
    tick();
    chk("rel_green", 32'(phase), 1);
    chk("rel_green_lamps", 32'(lamps), 32'b100001);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
